ffm_sensor_responder: RTL

//  Sensor-side end of the FFM polled UART link: waits for a request pulse on the dRX request line, then

---
 rtl/ffm_sensor_responder_if.sv | 22 ++
 rtl/ffm_sensor_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ffm_sensor_responder_if.sv
// ffm_sensor_responder_if: request, frame-write and UART signals of the FFM sensor responder
// master: drives rq_in and the write port, observes tx/busy/done/wr_err/rq_miss
// slave : the responder itself
interface ffm_sensor_responder_if;
    logic       rq_in;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       tx;
    logic       busy;
    logic       done;
    logic       wr_err;
    logic       rq_miss;
    modport master (
        output rq_in, wr_en, wr_addr, wr_data,
        input  tx, busy, done, wr_err, rq_miss
    );
    modport slave (
        input  rq_in, wr_en, wr_addr, wr_data,
        output tx, busy, done, wr_err, rq_miss
    );
endinterface

// File: rtl/ffm_sensor_responder.sv
// ffm_sensor_responder: sensor-side end of the FFM polled UART link, sends one frame per request
// Ports:
//   clk80         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   bus.rq_in     async request line, a falling edge starts a frame
//   bus.wr_en/wr_addr/wr_data  frame buffer write port (idle only)
//   bus.tx        UART output, 8N1, LSB first, idle high
//   bus.busy      high from request detect until the final stop bit ends
//   bus.done      one-cycle pulse after the final stop bit
//   bus.wr_err    one-cycle pulse for a rejected write
//   bus.rq_miss   one-cycle pulse for a request seen while busy
// Define FFM_RESP_PARITY_EN to insert an even-parity bit after the data bits.
module ffm_sensor_responder #(
    parameter int CLK_DIV     = 16,
    parameter int FRAME_LEN   = 15,
    parameter int START_DELAY = 30,
    parameter int GAP_BITS    = 10
) (
    input logic clk80,
    input logic reset_n,
    ffm_sensor_responder_if.slave bus
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, DELAY, GAP, START, DATA, PARITY, STOP} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0] bits, bits_d, sh, sh_d;
    logic [3:0] idx, idx_d;
    logic [7:0] mem [16];
    logic rq_s1, rq_s2, rq_s3, det, start, wr_ok, bit_end, tx_d, done_d;
`ifdef FFM_RESP_PARITY_EN
    logic par, par_d;
`endif
    assign det = rq_s3 & ~rq_s2;
    // the done cycle still counts as busy for requests
    assign start = det && state == IDLE && !bus.done;
    assign wr_ok = bus.wr_en && state == IDLE && {1'b0, bus.wr_addr} < 5'(FRAME_LEN);
    assign bit_end = cnt == CW'(CLK_DIV - 1);
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            rq_s1       <= 1'b0;
            rq_s2       <= 1'b0;
            rq_s3       <= 1'b0;
            bus.wr_err  <= 1'b0;
            bus.rq_miss <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            rq_s1       <= bus.rq_in;
            rq_s2       <= rq_s1;
            rq_s3       <= rq_s2;
            bus.wr_err  <= bus.wr_en && !wr_ok;
            bus.rq_miss <= det && !start;
            if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
        end
    end
    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= '0;
            idx      <= '0;
            sh       <= '0;
            bus.tx   <= 1'b1;
            bus.done <= 1'b0;
`ifdef FFM_RESP_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bits     <= bits_d;
            idx      <= idx_d;
            sh       <= sh_d;
            bus.tx   <= tx_d;
            bus.done <= done_d;
`ifdef FFM_RESP_PARITY_EN
            par      <= par_d;
`endif
        end
    end
    // tx is registered from the next state so the line changes on the same edge as the state
    always_comb begin
        state_d = state;
        cnt_d   = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
        bits_d  = bit_end ? bits + 8'd1 : bits;
        idx_d   = idx;
        sh_d    = sh;
        done_d  = 1'b0;
`ifdef FFM_RESP_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: begin
                bits_d = '0;
                if (start) begin
                    state_d = DELAY;
                    idx_d   = '0;
                end
            end
            DELAY: if (bit_end && bits == 8'(START_DELAY - 1)) begin
                state_d = GAP;
                bits_d  = '0;
            end
            GAP: if (bit_end && bits == 8'(GAP_BITS - 1)) begin
                state_d = START;
                bits_d  = '0;
                sh_d    = mem[idx];
`ifdef FFM_RESP_PARITY_EN
                par_d   = ^mem[idx];
`endif
            end
            START: if (bit_end) begin
                state_d = DATA;
                bits_d  = '0;
            end
            DATA: if (bit_end) begin
                sh_d = {1'b0, sh[7:1]};
                if (bits == 8'd7) begin
`ifdef FFM_RESP_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                    bits_d = '0;
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                bits_d  = '0;
            end
            STOP: if (bit_end) begin
                bits_d = '0;
                if (idx == 4'(FRAME_LEN - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = GAP;
                    idx_d   = idx + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef FFM_RESP_PARITY_EN
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
`endif
    end
endmodule
